estu_result_uart_tx: RTL and testbench
======================================

ESTU_RESULT_UART_TX -- requirements
Module: estu_result_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clocks per UART bit (12 MHz / 3 Mbaud); legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning result-FIFO entries (power of two, 2..16).
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  one-cycle pulse marking a last-layer result.
REQ-006 SHALL have port i_data  input  13  last-layer result, sampled when i_valid=1.
REQ-007 SHALL have port o_txd  output  1  UART 8N1 serial line, LSB first, idle high.
REQ-008 SHALL have port o_busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-009 SHALL have port o_level  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-010 SHALL have port o_overflow  output  1  sticky flag: a result was dropped.

Function
REQ-011 SHALL write i_data into the FIFO on every cycle with i_valid=1 and FIFO not full, or full with a pop in the same cycle.
REQ-012 SHALL drop i_data when i_valid=1, FIFO full and no same-cycle pop; o_overflow SHALL go to 1 on the next edge and stay 1 until reset.
REQ-013 SHALL encode each result as a 2-byte frame: byte0 = {1'b1, 2'b00, data[12:8]}, byte1 = data[7:0]; byte0 sent first.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP with a byte-select bit (0 = byte0, 1 = byte1) and a 3-bit data-bit index.
REQ-015 IDLE: o_txd=1; if FIFO non-empty, pop the head, latch it, set byte-select=0, go to START.
REQ-016 START: o_txd=0 for CLK_DIV cycles, then DATA with bit index 0.
REQ-017 DATA: o_txd = current byte[index] for CLK_DIV cycles per bit; after index 7, go to STOP.
REQ-018 STOP: o_txd=1 for CLK_DIV cycles; then START with byte-select=1 if byte-select was 0; else, if FIFO non-empty, pop and START with byte-select=0; else IDLE.
REQ-019 No idle gap SHALL exist between byte0 and byte1, nor between back-to-back frames; one frame = 20*CLK_DIV cycles (80 at default).
REQ-020 o_txd SHALL be driven from a flop (glitch-free).
REQ-021 Latency: o_txd SHALL first go low on the second rising edge after the edge that sampled i_valid, when starting from IDLE with an empty FIFO.
REQ-022 Baud counter SHALL count 0..CLK_DIV-1 and reload at each bit boundary; bit boundaries SHALL be exact, with no cumulative drift.
REQ-023 o_level SHALL update on the edge after push/pop; simultaneous push and pop SHALL leave it unchanged.
REQ-024 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.
REQ-025 o_busy SHALL be 0 only in IDLE with o_level=0.

Reset
REQ-026 On i_rst=1 at a rising edge: FSM to IDLE, FIFO emptied, o_txd=1, o_busy=0, o_level=0, o_overflow=0, baud counter and bit index 0.
REQ-027 Reset mid-frame SHALL abort the frame; o_txd SHALL be 1 after that edge, and no partial byte SHALL resume after reset is released.
REQ-028 i_valid asserted while i_rst=1 SHALL be ignored.

Verification
REQ-029 Single result: i_valid pulse with i_data=13'h1ABC -> line decodes to bytes 0x9A then 0xBC at 3 Mbaud; o_busy low after 80+2 cycles; o_level peaks at 1.
REQ-030 Latency and timing: pulse at edge N -> o_txd=0 from edge N+2; each bit is exactly 4 cycles; stop bit of byte0 is followed immediately by start bit of byte1.
REQ-031 Burst: 4 pulses on consecutive cycles with data 0x0000, 0x1FFF, 0x0155, 0x0AAA -> byte stream 80 00, 9F FF, 81 55, 8A AA back-to-back; o_overflow=0.
REQ-032 Overflow: 6 consecutive pulses (data 1..6) from IDLE -> data 1 is popped, 2..5 fill the FIFO, 6 is dropped; o_overflow=1; line carries frames for 1..5 only.
REQ-033 Reset mid-frame: i_rst pulse 30 cycles after frame start with 2 entries queued -> o_txd=1 next edge, o_level=0, o_overflow=0; a new pulse 0x0001 then produces a clean 80 01 frame.
REQ-034 Wrap-around: 20 spaced pulses (one per 100 cycles, data = index) -> 20 correct frames in order, pointers wrapping 5 times, o_overflow=0.

Source files
------------

// File: rtl/estu_result_uart_tx.sv
// Queues 13-bit last-layer results and sends each one as two back-to-back 8N1 bytes (byte0 = {1,00,data[12:8]}, byte1 = data[7:0]).
// o_txd first drops two edges after i_valid is sampled; a result arriving with the FIFO full and no pop is dropped and sets o_overflow.
module estu_result_uart_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [12:0] i_data,
  output logic        o_txd,
  output logic        o_busy,
  output logic [4:0]  o_level,
  output logic        o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CNT_MAX  = 8'(CLK_DIV - 1);
  localparam logic [4:0] LVL_FULL = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            sel_q, sel_d;
  logic [12:0]     data_q, data_d;
  logic            txd_q, txd_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [12:0]     mem_q [FIFO_DEPTH];
  logic [12:0]     mem_d [FIFO_DEPTH];

  logic            pop;
  logic            push;
  logic            bit_end;
  logic            fifo_empty;
  logic [7:0]      cur_byte;

  assign bit_end    = (cnt_q == CNT_MAX);
  assign fifo_empty = (level_q == 5'd0);
  assign cur_byte   = sel_q ? data_q[7:0] : {3'b100, data_q[12:8]};

  // Transmit sequencer; pops happen only when leaving IDLE or at the end of a frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    data_d  = data_q;
    pop     = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
    end
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          sel_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!sel_q) begin
            sel_d   = 1'b1;
            state_d = START;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            sel_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current state one edge later, so o_txd comes straight from a flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte[idx_q];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    push     = i_valid && !i_rst && ((level_q != LVL_FULL) || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + {4'd0, push} - {4'd0, pop};
    ovf_d    = ovf_q || (i_valid && !push);
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      sel_q    <= 1'b0;
      data_q   <= 13'd0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_txd      = txd_q;
  assign o_busy     = (state_q != IDLE) || !fifo_empty;
  assign o_level    = level_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_estu_result_uart_tx.sv
// Bench for estu_result_uart_tx: line decoder plus a queue-based transmitter model, directed vectors and random traffic.
module tb_estu_result_uart_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int NBIT       = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [12:0] i_data;
  logic        o_txd;
  logic        o_busy;
  logic [4:0]  o_level;
  logic        o_overflow;

  estu_result_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_txd(o_txd), .o_busy(o_busy), .o_level(o_level), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t        tbl[6];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;

  logic [7:0]  cap[$];
  logic [7:0]  dq[$];
  logic [7:0]  exp_b[$];
  int          exp_t[$];

  logic [12:0] mq[$];
  bit          m_active = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_end = 0;

  logic [NBIT-1:0] mon_s;
  bit              mon_ab;
  bit              mon_ok;
  int              mon_st;
  logic [7:0]      mon_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] enc0(input logic [12:0] d);
    return {3'b100, d[12:8]};
  endfunction

  // Reference: FIFO as a queue; the transmitter takes a result when idle or exactly 20 bit times after the previous take.
  always @(posedge clk) begin : model
    bit pop;
    bit acc;
    logic [12:0] d;
    cyc++;
    if (i_rst) begin
      mq.delete();
      exp_b.delete();
      exp_t.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      pop = (mq.size() > 0) && (!m_active || cyc == m_end);
      if (m_active && cyc == m_end && !pop) m_active = 1'b0;
      acc = i_valid && ((mq.size() < FIFO_DEPTH) || pop);
      if (i_valid && !acc) m_ovf = 1'b1;
      if (pop) begin
        d = mq.pop_front();
        m_active = 1'b1;
        m_end = cyc + 20 * CLK_DIV;
        exp_b.push_back(enc0(d));
        exp_t.push_back(cyc + 1);
        exp_b.push_back(d[7:0]);
        exp_t.push_back(cyc + 1 + NBIT);
      end
      if (acc) mq.push_back(i_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(o_level), 32'(mq.size()));
      chk("busy", 32'(o_busy), 32'(m_active || mq.size() > 0));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
    end
  end

  // Line decoder: every cycle of each bit slot must hold the same level.
  always begin
    @(negedge clk);
    if (chk_en && !i_rst && o_txd === 1'b0) begin
      mon_s  = '0;
      mon_ab = 1'b0;
      mon_st = cyc;
      for (int k = 1; k < NBIT; k++) begin
        @(negedge clk);
        if (i_rst) begin
          mon_ab = 1'b1;
          break;
        end
        mon_s[k] = o_txd;
      end
      if (!mon_ab) begin
        mon_ok = 1'b1;
        for (int sl = 0; sl < 10; sl++)
          for (int k = 1; k < CLK_DIV; k++)
            if (mon_s[sl*CLK_DIV+k] !== mon_s[sl*CLK_DIV]) mon_ok = 1'b0;
        if (mon_s[0] !== 1'b0 || mon_s[9*CLK_DIV] !== 1'b1) mon_ok = 1'b0;
        for (int bi = 0; bi < 8; bi++) mon_b[bi] = mon_s[(bi+1)*CLK_DIV];
        chk("framing", 32'(mon_ok), 32'd1);
        cap.push_back(mon_b);
        chk("byte expected by model", 32'(exp_b.size() > 0), 32'd1);
        if (exp_b.size() > 0) begin
          chk("byte value", 32'(mon_b), 32'(exp_b.pop_front()));
          chk("byte start cycle", 32'(mon_st), 32'(exp_t.pop_front()));
        end
      end
    end
  end

  task automatic check_cap(input string nm);
    chk({nm, " byte count"}, 32'(cap.size()), 32'(dq.size()));
    for (int i = 0; i < dq.size() && i < cap.size(); i++) chk(nm, 32'(cap[i]), 32'(dq[i]));
    cap.delete();
    dq.delete();
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle within budget", 32'(n < max), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse(input logic [12:0] d);
    @(posedge clk);
    #1 i_valid = 1'b1;
    i_data = d;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic burst(input int n, input int base);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      #1 i_valid = 1'b1;
      i_data = (base < 0) ? tbl[k+1].data : 13'(base + k);
      @(posedge clk);
    end
    #1 i_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{13'h1ABC, 8'h9A, 8'hBC};
    tbl[1] = '{13'h0000, 8'h80, 8'h00};
    tbl[2] = '{13'h1FFF, 8'h9F, 8'hFF};
    tbl[3] = '{13'h0155, 8'h81, 8'h55};
    tbl[4] = '{13'h0AAA, 8'h8A, 8'hAA};
    tbl[5] = '{13'h0001, 8'h80, 8'h01};

    i_rst = 1'b1;
    i_valid = 1'b0;
    i_data = 13'd0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("reset txd", 32'(o_txd), 32'd1);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset level", 32'(o_level), 32'd0);
    chk("reset overflow", 32'(o_overflow), 32'd0);
    chk_en = 1'b1;

    // Single frames with latency checks around the sampling edge.
    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].data);
      @(negedge clk);
      chk("level after push", 32'(o_level), 32'd1);
      chk("txd before start", 32'(o_txd), 32'd1);
      @(negedge clk);
      chk("txd one edge after", 32'(o_txd), 32'd1);
      chk("level after pop", 32'(o_level), 32'd0);
      @(negedge clk);
      chk("txd low two edges after", 32'(o_txd), 32'd0);
      wait_idle(120);
      dq.push_back(tbl[i].b0);
      dq.push_back(tbl[i].b1);
      check_cap("single frame");
    end

    burst(4, -1);
    wait_idle(500);
    for (int i = 1; i < 5; i++) begin
      dq.push_back(tbl[i].b0);
      dq.push_back(tbl[i].b1);
    end
    check_cap("burst");
    chk("burst overflow", 32'(o_overflow), 32'd0);

    burst(6, 1);
    @(negedge clk);
    chk("overflow set", 32'(o_overflow), 32'd1);
    chk("level full", 32'(o_level), 32'(FIFO_DEPTH));
    wait_idle(600);
    for (int i = 1; i <= 5; i++) begin
      dq.push_back(enc0(13'(i)));
      dq.push_back(8'(i));
    end
    check_cap("overflow frames");
    chk("overflow sticky", 32'(o_overflow), 32'd1);

    // Reset 30 cycles into a frame with two results queued; i_valid during reset is ignored.
    burst(3, 13'h111);
    repeat (28) @(posedge clk);
    #1 i_rst = 1'b1;
    i_valid = 1'b1;
    i_data = 13'h1FFF;
    @(posedge clk);
    #1 i_rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("txd after reset", 32'(o_txd), 32'd1);
    chk("level after reset", 32'(o_level), 32'd0);
    chk("overflow after reset", 32'(o_overflow), 32'd0);
    chk("busy after reset", 32'(o_busy), 32'd0);
    repeat (60) @(negedge clk);
    check_cap("no resumed bytes");
    pulse(13'h0001);
    wait_idle(120);
    dq.push_back(8'h80);
    dq.push_back(8'h01);
    check_cap("clean frame after reset");

    for (int i = 0; i < 20; i++) begin
      pulse(13'(i));
      repeat (98) @(posedge clk);
    end
    wait_idle(200);
    for (int i = 0; i < 20; i++) begin
      dq.push_back(enc0(13'(i)));
      dq.push_back(8'(i));
    end
    check_cap("wrap-around");
    chk("wrap overflow", 32'(o_overflow), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1 i_valid = ($urandom_range(0, 24) == 0);
      i_data = 13'($urandom);
      i_rst = ($urandom_range(0, 1499) == 0);
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
    i_rst = 1'b0;
    wait_idle(1000);
    chk("model bytes drained", 32'(exp_b.size()), 32'd0);
    cap.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
